// File: rtl/axi4s_uart_tx_arbiter.sv
// Round-robin merge of several AXI4-Stream byte sources onto one UART transmit stream.
// Each granted packet is prefixed by a header byte 0xA0|port and guarded by an idle timeout.
module axi4s_uart_tx_arbiter #(
    parameter int NUM_PORTS    = 4,
    parameter int TIMEOUT_TICS = 1000000
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic [NUM_PORTS-1:0]   s_tvalid,
    output logic [NUM_PORTS-1:0]   s_tready,
    input  logic [8*NUM_PORTS-1:0] s_tdata,
    input  logic [NUM_PORTS-1:0]   s_tlast,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic [7:0]             m_tdata,
    output logic                   m_tlast,
    output logic [NUM_PORTS-1:0]   grant,
    output logic                   timeout_err
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_TICS);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_TICS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_PORTS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2
    } state_t;

    state_t               state_reg, state_next;
    logic [NUM_PORTS-1:0] grant_reg, grant_next;
    logic [IDX_W-1:0]     idx_reg, idx_next;
    logic [IDX_W-1:0]     last_grant_reg, last_grant_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic                 timeout_err_reg, timeout_err_next;

    logic [7:0]           port_byte [NUM_PORTS];
    logic                 rr_found;
    logic [IDX_W-1:0]     rr_idx;
    int                   rr_cand;
    logic                 sel_valid;
    logic                 sel_last;
    logic [7:0]           sel_byte;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign port_byte[gi] = s_tdata[8*gi +: 8];
            assign s_tready[gi]  = (state_reg == PAYLOAD) && grant_reg[gi] && m_tready;
        end
    endgenerate

    assign sel_valid   = s_tvalid[idx_reg];
    assign sel_last    = s_tlast[idx_reg];
    assign sel_byte    = port_byte[idx_reg];
    assign grant       = grant_reg;
    assign timeout_err = timeout_err_reg;

    // Scan from farthest to nearest so the first requester after last_grant wins.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        rr_cand  = 0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            rr_cand = int'(last_grant_reg) + 1 + k;
            if (rr_cand >= NUM_PORTS) begin
                rr_cand = rr_cand - NUM_PORTS;
            end
            if (s_tvalid[IDX_W'(rr_cand)]) begin
                rr_found = 1'b1;
                rr_idx   = IDX_W'(rr_cand);
            end
        end
    end

    always_comb begin
        state_next       = state_reg;
        grant_next       = grant_reg;
        idx_next         = idx_reg;
        last_grant_next  = last_grant_reg;
        cnt_next         = cnt_reg;
        timeout_err_next = 1'b0;
        m_tvalid         = 1'b0;
        m_tdata          = 8'h00;
        m_tlast          = 1'b0;
        case (state_reg)
            IDLE: begin
                if (rr_found) begin
                    state_next      = HEADER;
                    idx_next        = rr_idx;
                    last_grant_next = rr_idx;
                    grant_next      = NUM_PORTS'(1) << rr_idx;
                end
            end
            HEADER: begin
                m_tvalid = 1'b1;
                m_tdata  = {4'hA, 1'b0, 3'(idx_reg)};
                if (m_tready) begin
                    state_next = PAYLOAD;
                    cnt_next   = '0;
                end
            end
            PAYLOAD: begin
                m_tvalid = sel_valid;
                m_tdata  = sel_byte;
                m_tlast  = sel_last;
                if (sel_valid && m_tready) begin
                    cnt_next = '0;
                    if (sel_last) begin
                        state_next = IDLE;
                        grant_next = '0;
                    end
                end else if (!sel_valid) begin
                    // Only a silent source counts toward the timeout; a stalled sink never does.
                    if (cnt_reg >= CNT_MAX) begin
                        state_next       = IDLE;
                        grant_next       = '0;
                        cnt_next         = '0;
                        timeout_err_next = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_reg       <= IDLE;
            grant_reg       <= '0;
            idx_reg         <= '0;
            last_grant_reg  <= IDX_LAST;
            cnt_reg         <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            grant_reg       <= grant_next;
            idx_reg         <= idx_next;
            last_grant_reg  <= last_grant_next;
            cnt_reg         <= cnt_next;
            timeout_err_reg <= timeout_err_next;
        end
    end

endmodule

// File: tb/tb_axi4s_uart_tx_arbiter.sv
// Bench for the UART transmit arbiter: queue-driven sources, a packet-level
// round-robin reference model and per-scenario timing checks.
module tb_axi4s_uart_tx_arbiter;

    localparam int NP = 4;
    localparam int TT = 8;

    logic            aclk = 1'b0;
    logic            areset = 1'b1;
    logic [NP-1:0]   s_tvalid = '0;
    logic [NP-1:0]   s_tready;
    logic [8*NP-1:0] s_tdata = '0;
    logic [NP-1:0]   s_tlast = '0;
    logic            m_tvalid;
    logic            m_tready = 1'b0;
    logic [7:0]      m_tdata;
    logic            m_tlast;
    logic [NP-1:0]   grant;
    logic            timeout_err;

    axi4s_uart_tx_arbiter #(
        .NUM_PORTS(NP),
        .TIMEOUT_TICS(TT)
    ) dut (
        .aclk(aclk),
        .areset(areset),
        .s_tvalid(s_tvalid),
        .s_tready(s_tready),
        .s_tdata(s_tdata),
        .s_tlast(s_tlast),
        .m_tvalid(m_tvalid),
        .m_tready(m_tready),
        .m_tdata(m_tdata),
        .m_tlast(m_tlast),
        .grant(grant),
        .timeout_err(timeout_err)
    );

    always #5 aclk = ~aclk;

    logic [8:0] src_q [NP][$];
    logic [8:0] mq [NP][$];
    logic [8:0] out_q [$];
    logic [8:0] exp_q [$];
    bit         exp_trace [$];

    int total = 0;
    int bad = 0;
    int terr_cnt = 0;
    int cyc = 0;
    bit rand_ready = 1'b0;

    logic          smp_mv, smp_ml, smp_terr, smp_mready, smp_mhs;
    logic [7:0]    smp_md;
    logic [NP-1:0] smp_grant, smp_sready, hs;

    task automatic drive_sources();
        logic [8:0] w;
        for (int i = 0; i < NP; i++) begin
            if (src_q[i].size() > 0) begin
                w = src_q[i][0];
                s_tvalid[i]      = 1'b1;
                s_tdata[8*i +: 8] = w[7:0];
                s_tlast[i]       = w[8];
            end else begin
                s_tvalid[i]      = 1'b0;
                s_tdata[8*i +: 8] = 8'h00;
                s_tlast[i]       = 1'b0;
            end
        end
    endtask

    task automatic cycle();
        @(negedge aclk);
        smp_mv     = m_tvalid;
        smp_md     = m_tdata;
        smp_ml     = m_tlast;
        smp_terr   = timeout_err;
        smp_grant  = grant;
        smp_sready = s_tready;
        smp_mready = m_tready;
        smp_mhs    = m_tvalid && m_tready;
        hs         = s_tvalid & s_tready;
        if (smp_mhs) begin
            out_q.push_back({m_tlast, m_tdata});
            if (m_tlast) $display("packet end: byte=%h grant=%b cycle=%0d", m_tdata, grant, cyc);
        end
        if (timeout_err) terr_cnt++;
        @(posedge aclk);
        #1;
        cyc++;
        for (int i = 0; i < NP; i++) begin
            if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        end
        if (rand_ready) m_tready = ($urandom_range(0, 3) != 0);
        drive_sources();
    endtask

    task automatic push_byte(input int p, input logic [7:0] d, input logic l);
        src_q[p].push_back({l, d});
        mq[p].push_back({l, d});
    endtask

    task automatic push_rand_pkt(input int p, input int len);
        for (int k = 0; k < len; k++) push_byte(p, 8'($urandom_range(0, 255)), (k == len - 1));
    endtask

    task automatic clear_all();
        for (int i = 0; i < NP; i++) begin
            src_q[i].delete();
            mq[i].delete();
        end
        out_q.delete();
        terr_cnt = 0;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        clear_all();
        drive_sources();
        repeat (3) cycle();
        areset = 1'b0;
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < NP; i++) if (src_q[i].size() > 0) return 1'b0;
        return 1'b1;
    endfunction

    // Packet-level model: serve the next port with pending packets after the last one served.
    task automatic model_rr();
        int last;
        int p;
        bit any;
        logic [8:0] w;
        exp_q.delete();
        exp_trace.delete();
        last = NP - 1;
        while (1) begin
            any = 1'b0;
            p = 0;
            for (int k = 1; k <= NP && !any; k++) begin
                if (mq[(last + k) % NP].size() > 0) begin
                    any = 1'b1;
                    p = (last + k) % NP;
                end
            end
            if (!any) break;
            exp_trace.push_back(1'b0);
            exp_trace.push_back(1'b1);
            exp_q.push_back({1'b0, 8'hA0 | 8'(p)});
            do begin
                w = mq[p].pop_front();
                exp_q.push_back(w);
                exp_trace.push_back(1'b1);
            end while (!w[8] && mq[p].size() > 0);
            last = p;
        end
        exp_trace.push_back(1'b0);
    endtask

    task automatic drain(input int maxc, input string name);
        bit done = 1'b0;
        for (int i = 0; i < maxc && !done; i++) begin
            cycle();
            if (all_empty() && !smp_mv && smp_grant == '0) done = 1'b1;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL %s_drain: not idle after %0d cycles, required idle", name, maxc);
        end
    endtask

    task automatic compare_stream(input string name);
        int first = -1;
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            if (first < 0 && out_q[i] !== exp_q[i]) first = i;
        end
        total++;
        if (out_q.size() != exp_q.size() || first >= 0) begin
            bad++;
            $display("FAIL %s_stream: got %0d bytes, need %0d, first diff at %0d", name, out_q.size(), exp_q.size(), first);
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        m_tready = 1'b1;
        clear_all();
        drive_sources();
        repeat (2) cycle();
        for (int i = 0; i < 2; i++) begin
            cycle();
            total++;
            if ({smp_mv, smp_grant, smp_sready, smp_terr} !== {1'b0, 4'b0000, 4'b0000, 1'b0}) begin
                bad++;
                $display("FAIL reset_outputs: mv=%b grant=%b sready=%b terr=%b, need all zero", smp_mv, smp_grant, smp_sready, smp_terr);
            end
        end
        areset = 1'b0;
        cycle();
        total++;
        if (smp_mv !== 1'b0 || smp_grant !== 4'b0000) begin
            bad++;
            $display("FAIL reset_idle: mv=%b grant=%b, need 0/0000", smp_mv, smp_grant);
        end
    endtask

    task automatic test_single_packet();
        logic        e_mv [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [7:0]  e_md [6] = '{8'h00, 8'hA2, 8'h11, 8'h22, 8'h33, 8'h00};
        logic        e_ml [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [3:0]  e_gr [6] = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000};
        logic [3:0]  e_sr [6] = '{4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0000};
        do_reset();
        m_tready = 1'b1;
        push_byte(2, 8'h11, 1'b0);
        push_byte(2, 8'h22, 1'b0);
        push_byte(2, 8'h33, 1'b1);
        drive_sources();
        for (int i = 0; i < 6; i++) begin
            cycle();
            total++;
            if (smp_mv !== e_mv[i] || (e_mv[i] && (smp_md !== e_md[i] || smp_ml !== e_ml[i]))
                || smp_grant !== e_gr[i] || smp_sready !== e_sr[i]) begin
                bad++;
                $display("FAIL single_pkt_c%0d: mv=%b data=%h last=%b grant=%b sready=%b, need %b %h %b %b %b",
                         i, smp_mv, smp_md, smp_ml, smp_grant, smp_sready, e_mv[i], e_md[i], e_ml[i], e_gr[i], e_sr[i]);
            end
        end
    endtask

    task automatic test_round_robin();
        int gap_bad = 0;
        logic prev_mv = 1'b0;
        logic [7:0] hdr_q [$];
        logic [7:0] e_hdr [5] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
        do_reset();
        m_tready = 1'b1;
        for (int p = 0; p < NP; p++)
            for (int k = 0; k < 2; k++) push_rand_pkt(p, $urandom_range(1, 3));
        model_rr();
        drive_sources();
        for (int i = 0; i < exp_trace.size(); i++) begin
            cycle();
            if (smp_mv !== exp_trace[i]) gap_bad++;
            if (smp_mhs && !prev_mv) hdr_q.push_back(smp_md);
            prev_mv = smp_mv;
        end
        total++;
        if (gap_bad != 0) begin
            bad++;
            $display("FAIL rr_idle_gap: %0d cycles with wrong m_tvalid, need 0", gap_bad);
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (hdr_q.size() <= i || hdr_q[i] !== e_hdr[i]) begin
                bad++;
                $display("FAIL rr_header%0d: got %h, need %h", i, (hdr_q.size() > i) ? hdr_q[i] : 8'hxx, e_hdr[i]);
            end
        end
        compare_stream("rr");
    endtask

    task automatic test_random(input int iter);
        int unstable = 0;
        logic prev_stall = 1'b0;
        logic [8:0] prev_b = '0;
        do_reset();
        for (int p = 0; p < NP; p++) begin
            int n = $urandom_range(0, 3);
            for (int k = 0; k < n; k++) push_rand_pkt(p, $urandom_range(1, 4));
        end
        model_rr();
        rand_ready = 1'b1;
        m_tready = 1'b1;
        drive_sources();
        for (int i = 0; i < 1500 && !(all_empty() && out_q.size() >= exp_q.size()); i++) begin
            cycle();
            if (prev_stall && (!smp_mv || {smp_ml, smp_md} !== prev_b)) unstable++;
            prev_stall = smp_mv && !smp_mready;
            prev_b = {smp_ml, smp_md};
        end
        rand_ready = 1'b0;
        m_tready = 1'b1;
        drain(50, "rand");
        compare_stream($sformatf("rand%0d", iter));
        total++;
        if (unstable != 0) begin
            bad++;
            $display("FAIL rand%0d_stable: %0d changes while stalled, need 0", iter, unstable);
        end
        total++;
        if (terr_cnt != 0) begin
            bad++;
            $display("FAIL rand%0d_timeout: %0d pulses, need 0", iter, terr_cnt);
        end
    endtask

    task automatic test_stall();
        int hdr_bad = 0;
        int pay_bad = 0;
        do_reset();
        m_tready = 1'b0;
        push_byte(1, 8'h5A, 1'b0);
        push_byte(1, 8'h6B, 1'b0);
        push_byte(1, 8'h7C, 1'b1);
        drive_sources();
        cycle();
        for (int i = 0; i < 50; i++) begin
            cycle();
            if (smp_mv !== 1'b1 || smp_md !== 8'hA1 || smp_sready !== 4'b0000 || smp_terr !== 1'b0) hdr_bad++;
        end
        total++;
        if (hdr_bad != 0) begin
            bad++;
            $display("FAIL stall_header: %0d bad cycles, need 0", hdr_bad);
        end
        m_tready = 1'b1;
        cycle();
        m_tready = 1'b0;
        for (int i = 0; i < 50; i++) begin
            cycle();
            if (smp_mv !== 1'b1 || smp_md !== 8'h5A || smp_sready !== 4'b0000 || smp_terr !== 1'b0) pay_bad++;
        end
        total++;
        if (pay_bad != 0) begin
            bad++;
            $display("FAIL stall_payload: %0d bad cycles, need 0", pay_bad);
        end
        m_tready = 1'b1;
        drain(20, "stall");
        exp_q = '{9'h0A1, 9'h05A, 9'h06B, 9'h17C};
        compare_stream("stall");
        total++;
        if (terr_cnt != 0) begin
            bad++;
            $display("FAIL stall_timeout: %0d pulses, need 0", terr_cnt);
        end
    endtask

    task automatic test_timeout();
        bit found = 1'b0;
        do_reset();
        m_tready = 1'b1;
        push_byte(1, 8'h55, 1'b0);
        drive_sources();
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (smp_mhs && smp_md == 8'hA1) begin
                push_byte(3, 8'h77, 1'b1);
                drive_sources();
            end
            if (smp_mhs && smp_md == 8'h55) found = 1'b1;
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL timeout_first_byte: byte 55 not accepted within 20 cycles");
        end
        for (int k = 1; k <= 10; k++) begin
            cycle();
            if (k == 8) begin
                total++;
                if (smp_terr !== 1'b0 || smp_grant !== 4'b0010) begin
                    bad++;
                    $display("FAIL timeout_early: terr=%b grant=%b, need 0/0010", smp_terr, smp_grant);
                end
            end
            if (k == 9) begin
                total++;
                if (smp_terr !== 1'b1 || smp_grant !== 4'b0000 || smp_mv !== 1'b0) begin
                    bad++;
                    $display("FAIL timeout_pulse: terr=%b grant=%b mv=%b, need 1/0000/0", smp_terr, smp_grant, smp_mv);
                end
            end
            if (k == 10) begin
                total++;
                if (smp_terr !== 1'b0 || smp_mv !== 1'b1 || smp_md !== 8'hA3) begin
                    bad++;
                    $display("FAIL timeout_next_hdr: terr=%b mv=%b data=%h, need 0/1/A3", smp_terr, smp_mv, smp_md);
                end
            end
        end
        drain(20, "timeout");
        total++;
        if (terr_cnt != 1) begin
            bad++;
            $display("FAIL timeout_count: %0d pulses, need 1", terr_cnt);
        end
    endtask

    task automatic test_reset_mid(input bit keep0);
        int seen = 0;
        logic [7:0] want;
        do_reset();
        m_tready = 1'b1;
        push_rand_pkt(0, 6);
        push_rand_pkt(1, 2);
        drive_sources();
        for (int i = 0; i < 20 && seen < 2; i++) begin
            cycle();
            if (smp_mhs && (seen > 0 || smp_md == 8'hA0)) seen++;
        end
        total++;
        if (seen < 2) begin
            bad++;
            $display("FAIL rmid%0d_start: port 0 payload not reached", keep0);
        end
        areset = 1'b1;
        if (!keep0) src_q[0].delete();
        drive_sources();
        cycle();
        areset = 1'b0;
        cycle();
        total++;
        if ({smp_mv, smp_grant, smp_sready, smp_terr} !== {1'b0, 4'b0000, 4'b0000, 1'b0}) begin
            bad++;
            $display("FAIL rmid%0d_reset_vals: mv=%b grant=%b sready=%b terr=%b, need zero", keep0, smp_mv, smp_grant, smp_sready, smp_terr);
        end
        cycle();
        want = keep0 ? 8'hA0 : 8'hA1;
        total++;
        if (smp_mv !== 1'b1 || smp_md !== want) begin
            bad++;
            $display("FAIL rmid%0d_next_hdr: mv=%b data=%h, need 1/%h", keep0, smp_mv, smp_md, want);
        end
        drain(40, "rmid");
        total++;
        if (terr_cnt != 0) begin
            bad++;
            $display("FAIL rmid%0d_timeout: %0d pulses, need 0", keep0, terr_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_round_robin();
        for (int it = 0; it < 4; it++) test_random(it);
        test_stall();
        test_timeout();
        test_reset_mid(1'b1);
        test_reset_mid(1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
